// File: rtl/sccb_slave_if.sv
// sccb_slave_if: SCCB bus pins plus the register-write report of the responder.
//   i_SIO_C, i_SIO_D : SCCB clock/data from the master (asynchronous to the system clock)
//   o_fWrite         : one-cycle write strobe, o_Addr/o_Data valid in that cycle
//   o_Addr, o_Data   : last received sub-address / data byte
//   o_fBusy          : transaction in progress (START seen, STOP not yet seen)
//   o_fIdErr         : one-cycle pulse on device ID mismatch
`timescale 1ns / 1ps
interface sccb_slave_if;
  logic       i_SIO_C;
  logic       i_SIO_D;
  logic       o_fWrite;
  logic [7:0] o_Addr;
  logic [7:0] o_Data;
  logic       o_fBusy;
  logic       o_fIdErr;

  modport master (
    output i_SIO_C, i_SIO_D,
    input  o_fWrite, o_Addr, o_Data, o_fBusy, o_fIdErr
  );

  modport slave (
    input  i_SIO_C, i_SIO_D,
    output o_fWrite, o_Addr, o_Data, o_fBusy, o_fIdErr
  );
endinterface

// File: rtl/sccb_slave.sv
// sccb_slave: SCCB write responder. Oversamples SIO_C/SIO_D with the system clock and
// decodes 3-phase writes (device ID, sub-address, data), reporting each ID-matched
// complete write with a one-cycle strobe.
//   i_Clk  : system clock
//   i_Rst  : asynchronous active-high reset
//   bus    : sccb_slave_if.slave (SCCB pins in, write report out)
`timescale 1ns / 1ps
module sccb_slave #(
  parameter logic [7:0]  DEV_ID      = 8'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  sccb_slave_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StId,
    StSubaddr,
    StData,
    StWaitStop
  } state_e;

  // Synchronizers and previous-value flops reset to 1: the idle bus is high.
  logic [SYNC_STAGES-1:0] c_sync;
  logic [SYNC_STAGES-1:0] d_sync;
  logic                   p_c;
  logic                   p_d;
  logic                   s_c;
  logic                   s_d;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      c_sync <= '1;
      d_sync <= '1;
      p_c    <= 1'b1;
      p_d    <= 1'b1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], bus.i_SIO_C};
      d_sync <= {d_sync[SYNC_STAGES-2:0], bus.i_SIO_D};
      p_c    <= s_c;
      p_d    <= s_d;
    end
  end

  assign s_c = c_sync[SYNC_STAGES-1];
  assign s_d = d_sync[SYNC_STAGES-1];

  logic c_rise;
  logic start_det;
  logic stop_det;

  // START/STOP require C high in both samples, so a simultaneous C/D change is neither.
  assign c_rise    = s_c & ~p_c;
  assign start_det = s_c & p_c & p_d & ~s_d;
  assign stop_det  = s_c & p_c & ~p_d & s_d;

  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shreg_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       write_q;
  logic       id_err_q;
  logic       busy_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      write_q   <= 1'b0;
      id_err_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      write_q  <= 1'b0;
      id_err_q <= 1'b0;
      if (start_det) begin
        // Repeated START restarts framing from the ID byte in any state.
        state_q   <= StId;
        bit_cnt_q <= 4'd0;
        shreg_q   <= 8'h00;
        busy_q    <= 1'b1;
      end else if (stop_det && (state_q != StIdle)) begin
        // Any partial byte is dropped; SUBADDR already loaded o_Addr for a 2-phase write.
        state_q   <= StIdle;
        bit_cnt_q <= 4'd0;
        shreg_q   <= 8'h00;
        busy_q    <= 1'b0;
      end else if (c_rise && (state_q != StIdle)) begin
        if (bit_cnt_q != 4'd8) begin
          shreg_q   <= {shreg_q[6:0], s_d};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end else begin
          // Ninth (don't-care) bit: its value is ignored, the byte completes here.
          bit_cnt_q <= 4'd0;
          case (state_q)
            StId: begin
              if (shreg_q == DEV_ID) begin
                state_q <= StSubaddr;
              end else begin
                id_err_q <= 1'b1;
                state_q  <= StWaitStop;
              end
            end
            StSubaddr: begin
              addr_q  <= shreg_q;
              state_q <= StData;
            end
            StData: begin
              data_q  <= shreg_q;
              write_q <= 1'b1;
              state_q <= StWaitStop;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.o_fWrite = write_q;
  assign bus.o_Addr   = addr_q;
  assign bus.o_Data   = data_q;
  assign bus.o_fBusy  = busy_q;
  assign bus.o_fIdErr = id_err_q;

endmodule

// File: doc/sccb_slave.md
Name: sccb_slave

Overview:
- SCCB responder that oversamples SIO_C/SIO_D with the system clock and decodes 3-phase write transactions: device ID, sub-address, data.
- On each complete, ID-matched write it emits a one-cycle write strobe with address and data.
- Acts as a camera-side register-write target for simulation and on-chip loopback checks against the SCCB master.

Parameters:
- DEV_ID, 8'h42, expected 8-bit device ID byte, compared on all 8 bits including the R/W LSB.
- SYNC_STAGES, 2, synchronizer flops on each bus input (minimum 2).

Ports:
- i_Clk  input  1  system clock.
- i_Rst  input  1  asynchronous, active-high reset.
- i_SIO_C  input  1  SCCB clock from master (asynchronous).
- i_SIO_D  input  1  SCCB data from master (asynchronous).
- o_fWrite  output  1  one-cycle pulse; o_Addr/o_Data valid in that cycle.
- o_Addr  output  8  last received sub-address.
- o_Data  output  8  last received data byte.
- o_fBusy  output  1  high from start detection to stop detection.
- o_fIdErr  output  1  one-cycle pulse on ID mismatch.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; o_Addr = o_Data = 8'h00; state IDLE; bit counter 0; shift register 0; synchronizers and previous-value flops = 1 (bus idle high).
- Input sampling:
  - s_C/s_D are the synchronized inputs; p_C/p_D are their values one cycle earlier.
  - C rise = s_C & ~p_C.
  - START = s_C & p_C & p_D & ~s_D.
  - STOP = s_C & p_C & ~p_D & s_D.
  - A cycle where C and D change together is neither START nor STOP. If C rose in that cycle, bit capture uses s_D.
- Bit capture:
  - On C rise during an active phase: shift s_D in MSB-first, then increment the bit counter 0..8.
  - Bit 9 (counter == 8) is the SCCB don't-care bit. Its value is ignored. On its C rise the byte completes and the counter returns to 0.
- States and transitions:
  - IDLE: o_fBusy = 0. START -> ID.
  - ID: on byte completion, byte == DEV_ID -> SUBADDR; else pulse o_fIdErr -> WAIT_STOP.
  - SUBADDR: on byte completion, load o_Addr -> DATA. A STOP here is a 2-phase write: o_Addr stays updated, no o_fWrite, -> IDLE.
  - DATA: on byte completion, load o_Data and assert o_fWrite for exactly one cycle (the cycle after the completing C rise is detected) -> WAIT_STOP.
  - WAIT_STOP: all further bytes ignored; no strobe; STOP -> IDLE.
- Global rules:
  - START in any state (repeated start) clears the bit counter and shift register and goes to ID. o_fBusy stays 1.
  - STOP in any non-IDLE state -> IDLE, o_fBusy = 0 the next cycle. A partial byte is discarded with no strobe.
  - START/STOP has priority over C rise in the same cycle (cannot occur with legal timing).
- Latency: pin change to s_* is SYNC_STAGES cycles. o_fWrite rises SYNC_STAGES+1 cycles after the 27th SIO_C rising edge.
- Mid-operation reset: immediate return to reset values. After release, the block ignores the bus until the next START.
- o_Addr/o_Data hold their values between transactions. o_fWrite and o_fIdErr are never high in the same cycle.

Test Plan:
- Reset, then write ID 0x42, addr 0x11, data 0x22 (bit 9 driven 0) at 100 kHz with 500 kHz i_Clk -> exactly one o_fWrite pulse with o_Addr = 0x11, o_Data = 0x22; o_fBusy high START..STOP; o_fIdErr never high.
- ID 0x43 (read ID), addr 0x11, data 0x22 -> o_fIdErr pulses once after byte 1; no o_fWrite; o_Addr/o_Data keep prior values 0x11/0x22 (or 0x00 after reset).
- ID 0x42, addr 0x3A, then STOP (2-phase) -> o_Addr = 0x3A, no o_fWrite, o_fBusy falls after STOP.
- ID 0x42, addr 0x05, 4 data bits, repeated START, then full 0x42/0x06/0x77 -> single o_fWrite with 0x06/0x77; nothing from the aborted frame.
- Full write with bit-9 driven 1 on all bytes, plus a 4th byte 0xFF -> one o_fWrite with the 3rd-byte data; 4th byte ignored; bit-9 value has no effect.
- Assert i_Rst during the data byte of 0x42/0x11/0x22, release, then send 0x42/0x12/0x34 -> outputs 0 immediately; no strobe for the first frame; one strobe with 0x12/0x34.
